fsk_nco_sched: RTL and testbench

- Symbol scheduler and configuration controller for the FSK phase-accumulator NCO (dds_st-class core: phi_inc_i/freq_mod_i/clken in, out_valid back).
- Accepts one data bit per symbol over a valid/ready handshake and maps it to a mark/space phase increment held for SPS NCO clocks.
- Owns the NCO clock enable, pipeline warm-up, idle tone, underrun reporting and run-time retuning.

---
 rtl/fsk_nco_pkg.sv | 20 ++
 rtl/fsk_nco_sched_if.sv | 30 +++
 rtl/fsk_cfg_regs.sv | 65 ++++++
 rtl/fsk_nco_sched.sv | 95 +++++++++
 tb/tb_fsk_nco_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsk_nco_pkg.sv
// Shared types and constants for the FSK NCO symbol scheduler.
package fsk_nco_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] CFG_MARK  = 2'd0;
    localparam logic [1:0] CFG_SPACE = 2'd1;
    localparam logic [1:0] CFG_SPS   = 2'd2;
    localparam logic [1:0] CFG_FMOD  = 2'd3;

    localparam logic [24:0] DEF_MARK_INC  = 25'd1342177;
    localparam logic [24:0] DEF_SPACE_INC = 25'd671089;
    localparam logic [15:0] DEF_SPS_VAL   = 16'd8;

endpackage

// File: rtl/fsk_nco_sched_if.sv
// Bit/config/NCO-side signal bundle of the FSK scheduler.
interface fsk_nco_sched_if #(
    parameter int APR  = 25,
    parameter int APRF = 25
);
    logic            en;
    logic            cfg_we;
    logic [1:0]      cfg_sel;
    logic [APR-1:0]  cfg_data;
    logic            bit_valid;
    logic            bit_data;
    logic            bit_ready;
    logic            nco_valid;
    logic            nco_clken;
    logic [APR-1:0]  phi_inc_o;
    logic [APRF-1:0] freq_mod_o;
    logic            sym_start;
    logic            underrun;
    logic            mod_valid;

    modport master (
        output en, cfg_we, cfg_sel, cfg_data, bit_valid, bit_data, nco_valid,
        input  bit_ready, nco_clken, phi_inc_o, freq_mod_o, sym_start, underrun, mod_valid
    );

    modport slave (
        input  en, cfg_we, cfg_sel, cfg_data, bit_valid, bit_data, nco_valid,
        output bit_ready, nco_clken, phi_inc_o, freq_mod_o, sym_start, underrun, mod_valid
    );
endinterface

// File: rtl/fsk_cfg_regs.sv
// Staging/active configuration pairs. Writes land in staging; i_apply promotes
// staging to active, and o_nxt_* expose the value the active copy is about to take.
module fsk_cfg_regs
    import fsk_nco_pkg::*;
#(
    parameter int               APR       = 25,
    parameter int               APRF      = 25,
    parameter int               SPS_W     = 16,
    parameter logic [APR-1:0]   DEF_MARK  = DEF_MARK_INC,
    parameter logic [APR-1:0]   DEF_SPACE = DEF_SPACE_INC,
    parameter logic [SPS_W-1:0] DEF_SPS   = DEF_SPS_VAL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_we,
    input  logic [1:0]       i_sel,
    input  logic [APR-1:0]   i_data,
    input  logic             i_apply,
    output logic [APR-1:0]   o_nxt_mark,
    output logic [APR-1:0]   o_nxt_space,
    output logic [SPS_W-1:0] o_sps,
    output logic [APRF-1:0]  o_fmod
);
    logic [APR-1:0]   r_stg_mark, r_stg_space, r_act_mark, r_act_space;
    logic [SPS_W-1:0] r_stg_sps, r_act_sps;
    logic [APRF-1:0]  r_stg_fmod, r_act_fmod;
    logic [SPS_W-1:0] w_sps_raw, w_sps_wr;

    // Symbols shorter than two clocks would leave no off-boundary cycle.
    assign w_sps_raw = SPS_W'(i_data);
    assign w_sps_wr  = (w_sps_raw < SPS_W'(2)) ? SPS_W'(2) : w_sps_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stg_mark  <= DEF_MARK;
            r_stg_space <= DEF_SPACE;
            r_stg_sps   <= DEF_SPS;
            r_stg_fmod  <= '0;
            r_act_mark  <= DEF_MARK;
            r_act_space <= DEF_SPACE;
            r_act_sps   <= DEF_SPS;
            r_act_fmod  <= '0;
        end else begin
            if (i_we) begin
                case (i_sel)
                    CFG_MARK:  r_stg_mark  <= i_data;
                    CFG_SPACE: r_stg_space <= i_data;
                    CFG_SPS:   r_stg_sps   <= w_sps_wr;
                    default:   r_stg_fmod  <= APRF'(i_data);
                endcase
            end
            if (i_apply) begin
                r_act_mark  <= r_stg_mark;
                r_act_space <= r_stg_space;
                r_act_sps   <= r_stg_sps;
                r_act_fmod  <= r_stg_fmod;
            end
        end
    end

    assign o_nxt_mark  = i_apply ? r_stg_mark  : r_act_mark;
    assign o_nxt_space = i_apply ? r_stg_space : r_act_space;
    assign o_sps       = r_act_sps;
    assign o_fmod      = r_act_fmod;
endmodule

// File: rtl/fsk_nco_sched.sv
// FSK symbol scheduler: maps one handshaked bit per symbol to a mark/space
// increment held for sps NCO clocks, with warm-up, drain and underrun handling.
module fsk_nco_sched
    import fsk_nco_pkg::*;
#(
    parameter int               APR       = 25,
    parameter int               APRF      = 25,
    parameter int               SPS_W     = 16,
    parameter logic [APR-1:0]   DEF_MARK  = 25'd1342177,
    parameter logic [APR-1:0]   DEF_SPACE = 25'd671089,
    parameter logic [SPS_W-1:0] DEF_SPS   = 16'd8
) (
    input  logic           clk,
    input  logic           reset_n,
    fsk_nco_sched_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic [SPS_W-1:0] r_cnt;
    logic [APR-1:0]   r_phi;
    logic             r_sym_start, r_underrun;
    logic             w_last, w_bnd, w_take, w_apply;
    logic [APR-1:0]   w_nxt_mark, w_nxt_space;
    logic [SPS_W-1:0] w_sps;
    logic [APRF-1:0]  w_fmod;

    fsk_cfg_regs #(
        .APR(APR), .APRF(APRF), .SPS_W(SPS_W),
        .DEF_MARK(DEF_MARK), .DEF_SPACE(DEF_SPACE), .DEF_SPS(DEF_SPS)
    ) u_cfg (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_we       (bus.cfg_we),
        .i_sel      (bus.cfg_sel),
        .i_data     (bus.cfg_data),
        .i_apply    (w_apply),
        .o_nxt_mark (w_nxt_mark),
        .o_nxt_space(w_nxt_space),
        .o_sps      (w_sps),
        .o_fmod     (w_fmod)
    );

    assign w_last = (r_cnt == w_sps - SPS_W'(1));

    // The first WARM cycle with nco_valid is the boundary that opens RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_bnd       = 1'b0;
        case (r_state)
            IDLE: if (bus.en) w_state_nxt = WARM;
            WARM: begin
                w_bnd = bus.nco_valid;
                if (!bus.en)             w_state_nxt = IDLE;
                else if (bus.nco_valid)  w_state_nxt = RUN;
            end
            RUN, DRAIN: begin
                w_bnd = w_last;
                if (w_last) w_state_nxt = bus.en ? RUN : IDLE;
                else        w_state_nxt = bus.en ? RUN : DRAIN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_take  = w_bnd && bus.en;
    assign w_apply = w_bnd || (r_state == IDLE && bus.en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_phi       <= '0;
            r_sym_start <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sym_start <= w_take;
            r_underrun  <= w_take && !bus.bit_valid;
            if (w_bnd || r_state == IDLE || r_state == WARM) r_cnt <= '0;
            else                                             r_cnt <= r_cnt + SPS_W'(1);
            // An empty or declined boundary, and the idle tone, all fall back to space.
            if (w_take && bus.bit_valid && bus.bit_data)
                r_phi <= w_nxt_mark;
            else if (w_bnd || r_state == IDLE || r_state == WARM)
                r_phi <= w_nxt_space;
        end
    end

    assign bus.bit_ready  = w_take;
    assign bus.nco_clken  = (r_state != IDLE);
    assign bus.phi_inc_o  = r_phi;
    assign bus.freq_mod_o = w_fmod;
    assign bus.sym_start  = r_sym_start;
    assign bus.underrun   = r_underrun;
    assign bus.mod_valid  = bus.nco_valid && (r_state == RUN || r_state == DRAIN);
endmodule

// File: tb/tb_fsk_nco_sched.sv
// Directed bench for fsk_nco_sched: warm-up, streaming, underrun, retune,
// shutdown/drain and asynchronous reset, each scenario checked inline.
module tb_fsk_nco_sched;
    import fsk_nco_pkg::*;

    localparam logic [24:0] MARK  = 25'd1342177;
    localparam logic [24:0] SPACE = 25'd671089;
    localparam logic [24:0] MARK2 = 25'd2000000;
    localparam logic [24:0] FMOD  = 25'd12345;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    fsk_nco_sched_if #(.APR(25), .APRF(25)) bus ();

    fsk_nco_sched dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_data = '0;
        bus.bit_valid = 1'b0; bus.bit_data = 1'b0; bus.nco_valid = 1'b0;
        reset_n = 1'b0;
        tick(); tick();
        n_tests++;
        if ({bus.nco_clken, bus.bit_ready, bus.sym_start, bus.underrun, bus.mod_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {bus.nco_clken, bus.bit_ready, bus.sym_start, bus.underrun, bus.mod_valid});
        end
        n_tests++;
        if ({bus.phi_inc_o, bus.freq_mod_o} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_data: phi %0d fmod %0d want 0 0", bus.phi_inc_o, bus.freq_mod_o);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_warm();
        bus.en = 1'b1;
        #1;
        n_tests++;
        if (bus.nco_clken !== 1'b0) begin
            n_fail++;
            $display("FAIL warm_en_cycle: clken %b want 0", bus.nco_clken);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if ({bus.nco_clken, bus.bit_ready, bus.mod_valid, bus.phi_inc_o} !== {3'b100, SPACE}) begin
                n_fail++;
                $display("FAIL warm_wait[%0d]: clken/rdy/mv %b phi %0d want 100 %0d",
                         i, {bus.nco_clken, bus.bit_ready, bus.mod_valid}, bus.phi_inc_o, SPACE);
            end
        end
        tick();
        bus.nco_valid = 1'b1; bus.bit_valid = 1'b1; bus.bit_data = 1'b1;
        #1;
        n_tests++;
        if ({bus.bit_ready, bus.mod_valid, bus.nco_clken} !== 3'b101) begin
            n_fail++;
            $display("FAIL warm_ready: rdy/mv/clken %b want 101",
                     {bus.bit_ready, bus.mod_valid, bus.nco_clken});
        end
    endtask

    // Entered on the boundary where bit 1 is offered; streams 1,0,1.
    task automatic test_normal();
        logic [24:0] exp_phi [3] = '{MARK, SPACE, MARK};
        logic        nxt_bit [3] = '{1'b0, 1'b1, 1'b0};
        logic        nxt_vld [3] = '{1'b1, 1'b1, 1'b0};
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                tick();
                bus.bit_valid = (i == 7) ? nxt_vld[s] : 1'b0;
                bus.bit_data  = nxt_bit[s];
                #1;
                n_tests++;
                if ({bus.phi_inc_o, bus.sym_start, bus.underrun, bus.bit_ready, bus.mod_valid}
                    !== {exp_phi[s], i == 0, 1'b0, i == 7, 1'b1}) begin
                    n_fail++;
                    $display("FAIL normal[%0d.%0d]: phi %0d ss/ur/rdy/mv %b want phi %0d ss %b rdy %b",
                             s, i, bus.phi_inc_o,
                             {bus.sym_start, bus.underrun, bus.bit_ready, bus.mod_valid},
                             exp_phi[s], i == 0, i == 7);
                end
            end
        end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.bit_valid = (i == 7);
            bus.bit_data  = 1'b1;
            #1;
            n_tests++;
            if ({bus.phi_inc_o, bus.sym_start, bus.underrun, bus.bit_ready}
                !== {SPACE, i == 0, i == 0, i == 7}) begin
                n_fail++;
                $display("FAIL underrun[%0d]: phi %0d ss/ur/rdy %b want phi %0d ss %b ur %b rdy %b",
                         i, bus.phi_inc_o, {bus.sym_start, bus.underrun, bus.bit_ready},
                         SPACE, i == 0, i == 0, i == 7);
            end
        end
    endtask

    task automatic test_retune();
        int          len  [4] = '{8, 8, 2, 2};
        logic [24:0] ph   [4] = '{MARK, MARK2, SPACE, MARK2};
        logic [24:0] fm   [4] = '{25'd0, FMOD, FMOD, FMOD};
        int          wi   [4] = '{3, 2, 1, -1};
        logic [1:0]  ws   [4] = '{CFG_MARK, CFG_SPS, CFG_SPS, CFG_MARK};
        logic [24:0] wd   [4] = '{MARK2, 25'd1, 25'd8, 25'd0};
        logic        nb   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < len[s]; i++) begin
                tick();
                bus.cfg_we = 1'b0;
                if (i == wi[s]) begin
                    bus.cfg_we = 1'b1; bus.cfg_sel = ws[s]; bus.cfg_data = wd[s];
                end
                if (s == 0 && i == 5) begin
                    bus.cfg_we = 1'b1; bus.cfg_sel = CFG_FMOD; bus.cfg_data = FMOD;
                end
                bus.bit_valid = (i == len[s] - 1);
                bus.bit_data  = nb[s];
                #1;
                n_tests++;
                if ({bus.phi_inc_o, bus.freq_mod_o, bus.sym_start, bus.bit_ready}
                    !== {ph[s], fm[s], i == 0, i == len[s] - 1}) begin
                    n_fail++;
                    $display("FAIL retune[%0d.%0d]: phi %0d fmod %0d ss/rdy %b want phi %0d fmod %0d ss %b rdy %b",
                             s, i, bus.phi_inc_o, bus.freq_mod_o, {bus.sym_start, bus.bit_ready},
                             ph[s], fm[s], i == 0, i == len[s] - 1);
                end
            end
        end
        bus.cfg_we = 1'b0;
    endtask

    task automatic test_shutdown();
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.bit_valid = 1'b0;
            if (i == 1) bus.en = 1'b0;
            #1;
            n_tests++;
            if ({bus.phi_inc_o, bus.nco_clken, bus.bit_ready, bus.mod_valid} !== {MARK2, 3'b101}) begin
                n_fail++;
                $display("FAIL drain[%0d]: phi %0d clken/rdy/mv %b want %0d 101",
                         i, bus.phi_inc_o, {bus.nco_clken, bus.bit_ready, bus.mod_valid}, MARK2);
            end
        end
        tick();
        n_tests++;
        if ({bus.phi_inc_o, bus.nco_clken, bus.bit_ready, bus.mod_valid} !== {SPACE, 3'b000}) begin
            n_fail++;
            $display("FAIL drain_idle: phi %0d clken/rdy/mv %b want %0d 000",
                     bus.phi_inc_o, {bus.nco_clken, bus.bit_ready, bus.mod_valid}, SPACE);
        end
        bus.en = 1'b1;
        tick();
        bus.bit_valid = 1'b1; bus.bit_data = 1'b1;
        #1;
        n_tests++;
        if ({bus.nco_clken, bus.bit_ready, bus.mod_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL rewarm_ready: clken/rdy/mv %b want 110",
                     {bus.nco_clken, bus.bit_ready, bus.mod_valid});
        end
        // Brief en drop mid-symbol: symbol must run to completion with no warm-up.
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.en        = !(i == 1 || i == 2);
            bus.bit_valid = (i == 7);
            bus.bit_data  = 1'b0;
            #1;
            n_tests++;
            if ({bus.phi_inc_o, bus.nco_clken, bus.bit_ready, bus.mod_valid}
                !== {MARK2, 1'b1, i == 7, 1'b1}) begin
                n_fail++;
                $display("FAIL reenable[%0d]: phi %0d clken/rdy/mv %b want %0d 1 %b 1",
                         i, bus.phi_inc_o, {bus.nco_clken, bus.bit_ready, bus.mod_valid}, MARK2, i == 7);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.bit_valid = 1'b0;
            #1;
            n_tests++;
            if (bus.phi_inc_o !== SPACE) begin
                n_fail++;
                $display("FAIL pre_reset[%0d]: phi %0d want %0d", i, bus.phi_inc_o, SPACE);
            end
        end
        tick();
        bus.bit_valid = 1'b1; bus.bit_data = 1'b1;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.nco_clken, bus.bit_ready, bus.sym_start, bus.underrun, bus.mod_valid,
             bus.phi_inc_o, bus.freq_mod_o} !== 55'd0) begin
            n_fail++;
            $display("FAIL async_reset: ctl %b phi %0d fmod %0d want all 0",
                     {bus.nco_clken, bus.bit_ready, bus.sym_start, bus.underrun, bus.mod_valid},
                     bus.phi_inc_o, bus.freq_mod_o);
        end
        tick();
        bus.nco_valid = 1'b0; bus.bit_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        n_tests++;
        if ({bus.nco_clken, bus.mod_valid, bus.phi_inc_o} !== {2'b10, SPACE}) begin
            n_fail++;
            $display("FAIL rst_rewarm: clken/mv %b phi %0d want 10 %0d",
                     {bus.nco_clken, bus.mod_valid}, bus.phi_inc_o, SPACE);
        end
        tick();
        bus.nco_valid = 1'b1; bus.bit_valid = 1'b1; bus.bit_data = 1'b1;
        #1;
        n_tests++;
        if (bus.bit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready: rdy %b want 1", bus.bit_ready);
        end
        tick();
        bus.bit_valid = 1'b0;
        #1;
        n_tests++;
        if ({bus.phi_inc_o, bus.freq_mod_o, bus.sym_start} !== {MARK, 25'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_defaults: phi %0d fmod %0d ss %b want %0d 0 1",
                     bus.phi_inc_o, bus.freq_mod_o, bus.sym_start, MARK);
        end
    endtask

    initial begin
        test_reset();
        test_warm();
        test_normal();
        test_underrun();
        test_retune();
        test_shutdown();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
